// File: rtl/alu_vector_checker_if.sv
// ALU-side bus of the vector checker: stimulus out to the ALU, result/zero back.
interface alu_vector_checker_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport master (output alu_op, alu_a, alu_b, input alu_result, alu_zero);
    modport slave  (input alu_op, alu_a, alu_b, output alu_result, alu_zero);
endinterface

// File: rtl/alu_vector_checker.sv
// Vector RAM driven ALU checker: applies stored {op,a,b,exp} vectors and counts mismatches.
// Optional macro ALU_CHK_STOP_ON_ERR_EN ends the run at the first mismatching vector.
module alu_vector_checker #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 4,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [OPW+3*WIDTH-1:0]   wr_data,
    input  logic [AW:0]              num_vec,
    input  logic                     start,
    alu_vector_checker_if.master     alu,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [AW:0]              vec_cnt,
    output logic [AW:0]              err_cnt,
    output logic [AW-1:0]            fail_idx,
    output logic [WIDTH-1:0]         fail_result
);
    localparam int VW = OPW + 3 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t            state, state_nx;
    logic [VW-1:0]     ram [DEPTH];
    logic [VW-1:0]     cur_vec;
    logic [AW:0]       n_q;
    logic [AW:0]       n_new;
    logic [AW:0]       vec_inc;
    logic [SW-1:0]     wait_q;
    logic [WIDTH-1:0]  exp_q;
    logic              start_ok;
    logic              last_vec;
    logic              mismatch;

    always_ff @(posedge clk) begin
        if (wr_en && !busy) ram[wr_addr] <= wr_data;
    end

    assign cur_vec  = ram[vec_cnt[AW-1:0]];
    assign n_new    = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    assign vec_inc  = vec_cnt + 1'b1;
    assign last_vec = (vec_inc == n_q);
    assign start_ok = start && !busy && (state == ST_IDLE || state == ST_DONE);
    assign mismatch = (alu.alu_result != exp_q) || (alu.alu_zero != (exp_q == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) state_nx = (n_new == '0) ? ST_DONE : ST_APPLY;
            end
            ST_APPLY:  state_nx = ST_SETTLE;
            ST_SETTLE: if (wait_q == '0) state_nx = ST_CHECK;
            ST_CHECK: begin
`ifdef ALU_CHK_STOP_ON_ERR_EN
                state_nx = (last_vec || mismatch) ? ST_DONE : ST_APPLY;
`else
                state_nx = last_vec ? ST_DONE : ST_APPLY;
`endif
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu.alu_op  <= '0;
            alu.alu_a   <= '0;
            alu.alu_b   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            vec_cnt     <= '0;
            err_cnt     <= '0;
            fail_idx    <= '0;
            fail_result <= '0;
            n_q         <= '0;
            wait_q      <= '0;
            exp_q       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        n_q         <= n_new;
                        vec_cnt     <= '0;
                        err_cnt     <= '0;
                        fail_idx    <= '0;
                        fail_result <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                    end else if (state == ST_DONE && busy) begin
                        // First DONE cycle of a run publishes the verdict
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_cnt == '0);
                    end
                end
                ST_APPLY: begin
                    alu.alu_op <= cur_vec[VW-1 -: OPW];
                    alu.alu_a  <= cur_vec[3*WIDTH-1 -: WIDTH];
                    alu.alu_b  <= cur_vec[2*WIDTH-1 -: WIDTH];
                    exp_q      <= cur_vec[WIDTH-1:0];
                    wait_q     <= SW'(SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (wait_q != '0) wait_q <= wait_q - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            fail_idx    <= vec_cnt[AW-1:0];
                            fail_result <= alu.alu_result;
                        end
                    end
                    vec_cnt <= vec_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_vector_checker.sv
// Scoreboard bench for alu_vector_checker: directed test-plan runs plus randomized runs.
module tb_alu_vector_checker;
    localparam int W  = 32;
    localparam int OW = 4;
    localparam int D  = 16;
    localparam int ST = 2;

    typedef struct {
        int unsigned vc, err, fidx, pass, lat, start_edge;
        logic [W-1:0]  fres;
        logic [OW-1:0] op;
        logic [W-1:0]  a, b;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [OW+3*W-1:0] wr_data = '0;
    logic [4:0] num_vec = '0;
    logic start = 1'b0;
    logic busy, done, pass;
    logic [4:0] vec_cnt, err_cnt;
    logic [3:0] fail_idx;
    logic [W-1:0] fail_result;

    logic fault_sub = 1'b0;
    logic zero_stuck = 1'b0;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    logic done_q = 1'b0;

    logic [OW-1:0] m_op [D];
    logic [W-1:0]  m_a [D], m_b [D], m_exp [D];
    logic [OW-1:0] l_op = '0;
    logic [W-1:0]  l_a = '0, l_b = '0;
    exp_t sb [$];

    alu_vector_checker_if #(.WIDTH(W), .OPW(OW)) alu_if ();

    alu_vector_checker #(.WIDTH(W), .OPW(OW), .DEPTH(D), .SETTLE(ST)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .num_vec(num_vec), .start(start), .alu(alu_if),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .fail_idx(fail_idx), .fail_result(fail_result)
    );

    function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic fs);
        case (op)
            4'd0: return a + b;
            4'd1: return fs ? 32'd1 : a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            default: return a;
        endcase
    endfunction

    // Behavioural ALU sitting on the slave side of the bus
    assign alu_if.alu_result = alu_fn(alu_if.alu_op, alu_if.alu_a, alu_if.alu_b, fault_sub);
    assign alu_if.alu_zero   = zero_stuck ? 1'b0 : (alu_if.alu_result == '0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic predict(input int unsigned num, output exp_t e);
        int unsigned n;
        logic [W-1:0] r;
        logic z, mis;
        n = (num > D) ? D : num;
        e = '{default: '0};
        for (int unsigned i = 0; i < n; i++) begin
            r = alu_fn(m_op[i], m_a[i], m_b[i], fault_sub);
            z = zero_stuck ? 1'b0 : (r == '0);
            mis = (r != m_exp[i]) || (z != (m_exp[i] == '0));
            l_op = m_op[i]; l_a = m_a[i]; l_b = m_b[i];
            e.vc++;
            if (mis) begin
                if (e.err == 0) begin
                    e.fidx = i;
                    e.fres = r;
                end
                e.err++;
`ifdef ALU_CHK_STOP_ON_ERR_EN
                break;
`endif
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.lat  = e.vc * (ST + 2) + 1;
        e.op = l_op; e.a = l_a; e.b = l_b;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.start_edge, e.lat);
                check("vec_cnt", vec_cnt, e.vc);
                check("err_cnt", err_cnt, e.err);
                check("fail_idx", fail_idx, e.fidx);
                check("fail_result", fail_result, e.fres);
                check("pass", pass, e.pass);
                check("busy_done", busy, 0);
                check("alu_op", alu_if.alu_op, e.op);
                check("alu_a", alu_if.alu_a, e.a);
                check("alu_b", alu_if.alu_b, e.b);
            end
        end
        done_q = done;
    end

    task automatic write_raw(input int unsigned addr, input logic [OW-1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ex);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = addr[3:0];
        wr_data = {op, a, b, ex};
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_vec(input int unsigned addr, input logic [OW-1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ex);
        write_raw(addr, op, a, b, ex);
        m_op[addr] = op; m_a[addr] = a; m_b[addr] = b; m_exp[addr] = ex;
    endtask

    task automatic issue_start(input int unsigned num);
        exp_t e;
        @(negedge clk);
        predict(num, e);
        e.start_edge = cyc + 1;
        sb.push_back(e);
        num_vec = num[4:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run;
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        check("run_completed", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic load_directed;
        write_vec(0, 4'd0, 32'd5, 32'd3, 32'd8);
        write_vec(1, 4'd1, 32'd7, 32'd7, 32'd0);
        write_vec(2, 4'd2, 32'hF0, 32'h0F, 32'd0);
        write_vec(3, 4'd3, 32'd1, 32'd2, 32'd3);
    endtask

    task automatic load_random;
        logic [OW-1:0] op;
        logic [W-1:0] a, b, ex;
        for (int unsigned i = 0; i < D; i++) begin
            op = OW'($urandom_range(0, 5));
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            ex = alu_fn(op, a, b, 1'b0);
            case ($urandom_range(0, 7))
                0: ex = ex ^ (32'd1 << $urandom_range(0, 31));
                1: ex = '0;
                default: ;
            endcase
            write_vec(i, op, a, b, ex);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_counts", {vec_cnt, err_cnt, fail_idx}, 0);
        check("rst_fail_result", fail_result, 0);
        check("rst_alu", {alu_if.alu_op, alu_if.alu_a, alu_if.alu_b}, 0);
        reset_n = 1'b1;

        load_directed;
        issue_start(4);
        check("busy_after_start", busy, 1);
        wait_run;

        fault_sub = 1'b1;
        issue_start(4);
        wait_run;
        fault_sub = 1'b0;

        zero_stuck = 1'b1;
        issue_start(4);
        wait_run;
        zero_stuck = 1'b0;

        issue_start(0);
        wait_run;

        // Start and RAM write while busy must leave the run and RAM untouched
        issue_start(4);
        repeat (3) @(negedge clk);
        num_vec = 5'd1;
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = {4'd0, 32'd9, 32'd9, 32'h1234};
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        wait_run;
        issue_start(4);
        wait_run;

        // Reset asserted during SETTLE of vector 2
        fault_sub = 1'b1;
        issue_start(4);
        repeat (9) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy_done_pass", {busy, done, pass}, 0);
        check("abort_counts", {vec_cnt, err_cnt, fail_idx}, 0);
        check("abort_fail_result", fail_result, 0);
        check("abort_alu", {alu_if.alu_op, alu_if.alu_a, alu_if.alu_b}, 0);
        sb.delete();
        l_op = '0; l_a = '0; l_b = '0;
        @(negedge clk);
        reset_n = 1'b1;
        issue_start(4);
        wait_run;
        fault_sub = 1'b0;

        load_random;
        issue_start(D + 1);
        wait_run;

        for (int r = 0; r < 8; r++) begin
            load_random;
            fault_sub  = ($urandom_range(0, 3) == 0);
            zero_stuck = ($urandom_range(0, 3) == 0);
            issue_start($urandom_range(0, D + 1));
            wait_run;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
